// File: rtl/instr_controller_if.sv
// Bus between instruction source and the instruction controller: the start and
// load handshake, the instruction word, and the datapath control strobes.
interface instr_controller_if #(
  parameter int WIDTH = 16
);
  logic             s;
  logic             load;
  logic [WIDTH-1:0] instr;
  logic             w;
  logic             illegal;
  logic [2:0]       readnum;
  logic [2:0]       writenum;
  logic [1:0]       vsel;
  logic             loada;
  logic             loadb;
  logic             loadc;
  logic             loads;
  logic             write;
  logic             asel;
  logic             bsel;
  logic [1:0]       shift;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] sximm5;
  logic [WIDTH-1:0] sximm8;

  modport master (
    output s, load, instr,
    input  w, illegal, readnum, writenum, vsel, loada, loadb, loadc, loads,
           write, asel, bsel, shift, ALUop, sximm5, sximm8
  );

  modport slave (
    input  s, load, instr,
    output w, illegal, readnum, writenum, vsel, loada, loadb, loadc, loads,
           write, asel, bsel, shift, ALUop, sximm5, sximm8
  );
endinterface

// File: rtl/instr_controller.sv
// Instruction controller: holds the instruction register, classifies the
// instruction and walks a Moore FSM that issues one datapath strobe sequence
// per started instruction. All outputs derive from state and IR only.
module instr_controller #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  instr_controller_if.slave   ctl_if
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_WR_IMM
  } state_t;

  typedef enum logic [2:0] {
    C_MOVI, C_MOVR, C_ADD, C_CMP, C_AND, C_MVN, C_ILL
  } iclass_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  iclass_t          cls;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign ctl_if.sximm8 = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
  assign ctl_if.sximm5 = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};

  // Classify the held instruction; unlisted opcode/op pairs are illegal.
  always_comb begin
    cls = C_ILL;
    if (opcode == 3'b110) begin
      if (op == 2'b10)      cls = C_MOVI;
      else if (op == 2'b00) cls = C_MOVR;
    end else if (opcode == 3'b101) begin
      case (op)
        2'b00:   cls = C_ADD;
        2'b01:   cls = C_CMP;
        2'b10:   cls = C_AND;
        default: cls = C_MVN;
      endcase
    end
  end

  // IR accepts a new word only while idle, so a busy instruction cannot be corrupted.
  always_comb begin
    ir_d = ir_q;
    if (ctl_if.load && state_q == S_WAIT) ir_d = ctl_if.instr;
  end

  // State and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d         = state_q;
    ctl_if.w        = 1'b0;
    ctl_if.illegal  = 1'b0;
    ctl_if.readnum  = 3'b000;
    ctl_if.writenum = 3'b000;
    ctl_if.vsel     = 2'b00;
    ctl_if.loada    = 1'b0;
    ctl_if.loadb    = 1'b0;
    ctl_if.loadc    = 1'b0;
    ctl_if.loads    = 1'b0;
    ctl_if.write    = 1'b0;
    ctl_if.asel     = 1'b0;
    ctl_if.bsel     = 1'b0;
    ctl_if.shift    = 2'b00;
    ctl_if.ALUop    = 2'b00;
    case (state_q)
      S_WAIT: begin
        ctl_if.w = 1'b1;
        if (ctl_if.s) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          C_MOVI:         state_d = S_WR_IMM;
          C_MOVR, C_MVN:  state_d = S_GET_B;
          C_ADD, C_CMP,
          C_AND:          state_d = S_GET_A;
          default: begin
            ctl_if.illegal = 1'b1;
            state_d        = S_WAIT;
          end
        endcase
      end
      S_GET_A: begin
        ctl_if.readnum = rn;
        ctl_if.loada   = 1'b1;
        state_d        = S_GET_B;
      end
      S_GET_B: begin
        ctl_if.readnum = rm;
        ctl_if.loadb   = 1'b1;
        state_d        = S_EXEC;
      end
      S_EXEC: begin
        ctl_if.shift = sh;
        if (cls == C_CMP) begin
          ctl_if.ALUop = 2'b01;
          ctl_if.loads = 1'b1;
          state_d      = S_WAIT;
        end else begin
          // MOV reg passes B through by zeroing A and adding.
          ctl_if.asel  = (cls == C_MOVR);
          ctl_if.ALUop = (cls == C_MOVR) ? 2'b00 : op;
          ctl_if.loadc = 1'b1;
          state_d      = S_WR_REG;
        end
      end
      S_WR_REG: begin
        ctl_if.writenum = rd;
        ctl_if.write    = 1'b1;
        state_d         = S_WAIT;
      end
      S_WR_IMM: begin
        ctl_if.writenum = rn;
        ctl_if.vsel     = 2'b10;
        ctl_if.write    = 1'b1;
        state_d         = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule
